// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte producers.
// It takes one byte from the winning requester and issues a one-cycle send strobe.
// It then follows the transmitter busy flag until the frame completes.
// If busy never rises within ACK_TIMEOUT cycles, the byte is dropped and timeout_err pulses.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 15,
  parameter int GW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic [GW-1:0]        grant_id,
  output logic                 arb_busy,
  output logic                 timeout_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [GW-1:0] r_last_grant;
  logic [CW-1:0] r_ack_cnt;
  logic [7:0]    r_tx_data;
  logic          r_tx_send;
  logic [GW-1:0] r_grant_id;
  logic          r_timeout_err;

  logic [GW-1:0] w_winner;
  logic          w_any;
  logic [7:0]    w_win_data;
  logic          w_accept;
  logic          w_ack_expire;

  // Round-robin search starting just after the last grant; the nearest valid index wins
  always_comb begin
    logic [GW-1:0] idx;
    w_winner = '0;
    w_any    = 1'b0;
    idx      = '0;
    // Scanning from the farthest offset down lets the nearest valid requester overwrite the rest
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      idx = GW'((32'(r_last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        w_any    = 1'b1;
        w_winner = idx;
      end
    end
  end

  // Select the byte of the current winner
  always_comb begin
    w_win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_winner == GW'(i)) w_win_data = req_data[8*i +: 8];
    end
  end

  assign w_accept     = (r_state == IDLE) && !tx_busy && w_any;
  assign w_ack_expire = (r_ack_cnt == CW'(ACK_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a busy flag seen in WAIT_ACK takes priority over an expiring timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_next = SEND;
      SEND:      w_next = WAIT_ACK;
      WAIT_ACK:  if (tx_busy) w_next = WAIT_DONE;
                 else if (w_ack_expire) w_next = IDLE;
      WAIT_DONE: if (!tx_busy) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Combinational outputs: one-hot ready on the winner while idle, suppressed during reset
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_accept && !reset && (w_winner == GW'(i));
    end
    arb_busy = (r_state != IDLE);
  end

  // Registered datapath: captured byte, grant bookkeeping, send strobe, ack timer and error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_data     <= '0;
      r_tx_send     <= 1'b0;
      r_grant_id    <= '0;
      r_last_grant  <= GW'(NUM_REQ - 1);
      r_ack_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_send     <= w_accept;
      r_timeout_err <= (r_state == WAIT_ACK) && !tx_busy && w_ack_expire;
      if (w_accept) begin
        r_tx_data    <= w_win_data;
        r_grant_id   <= w_winner;
        r_last_grant <= w_winner;
      end
      if ((r_state == WAIT_ACK) && !tx_busy && !w_ack_expire) r_ack_cnt <= r_ack_cnt + 1'b1;
      else                                                    r_ack_cnt <= '0;
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_send     = r_tx_send;
  assign grant_id    = r_grant_id;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter.
// Expected (grant, byte) pairs are queued when requests are driven.
// Each tx_send strobe pops one pair and compares it against the DUT outputs.
module tb_uart_tx_arbiter;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_send;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            arb_busy;
  logic            timeout_err;

  int          n_chk = 0;
  int          n_pass = 0;
  int          send_cnt = 0;
  int          to_cnt = 0;
  int          cyc = 0;
  bit          prev_acc = 1'b0;
  bit          prev_send = 1'b0;
  bit          mdl_en = 1'b0;
  logic        mdl_busy = 1'b0;
  bit          ext_busy = 1'b0;
  int          mdl_pend = 0;
  int          mdl_hold = 0;
  int          busy_len = 20;
  int          base;
  logic [15:0] sb_q[$];
  logic [15:0] e;

  always #5 clk = ~clk;

  assign tx_busy = mdl_busy | ext_busy;

  uart_tx_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .grant_id(grant_id), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int n, input string tag);
    for (int i = 0; i < n && arb_busy; i++) step();
    chk(tag, arb_busy, 0);
  endtask

  task automatic wait_sends(input int target, input int n, input string tag);
    for (int i = 0; i < n && send_cnt < target; i++) step();
    chk(tag, send_cnt >= target, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Transmitter model: busy rises two cycles after the send strobe and stays high busy_len cycles
  always @(posedge clk) begin
    #1;
    if (mdl_en) begin
      if (mdl_pend > 0) begin
        mdl_pend--;
        if (mdl_pend == 0) begin
          mdl_busy = 1'b1;
          mdl_hold = busy_len;
        end
      end else if (mdl_busy) begin
        mdl_hold--;
        if (mdl_hold <= 0) mdl_busy = 1'b0;
      end
      if (tx_send) mdl_pend = 2;
    end else begin
      mdl_busy = 1'b0;
      mdl_pend = 0;
    end
  end

  // Output monitor on the falling edge: ready shape, send strobe against scoreboard, timeout delay
  always @(negedge clk) begin
    if (req_ready != '0) chk("ready_onehot", $onehot(req_ready), 1);
    if (tx_send) begin
      chk("send_latency", prev_acc, 1);
      chk("send_one_cycle", prev_send, 0);
      if (sb_q.size() == 0) chk("unexpected_send", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("grant_id", grant_id, e[15:8]);
        chk("tx_data", tx_data, e[7:0]);
      end
      send_cnt++;
      cyc = 0;
    end else cyc++;
    if (timeout_err) begin
      chk("timeout_delay", cyc, 16);
      chk("timeout_idle", arb_busy, 0);
      to_cnt++;
    end
    prev_acc  = |(req_ready & req_valid);
    prev_send = tx_send;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    // Reset values, with a request already pending while reset is high
    reset = 1'b1;
    req_valid = 4'b0001;
    req_data = '0;
    req_data[7:0] = 8'hA5;
    step();
    chk("rst_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_send", tx_send, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_arb_busy", arb_busy, 0);
    chk("rst_timeout", timeout_err, 0);
    step();
    reset = 1'b0;
    mdl_en = 1'b1;
    #1;
    chk("t1_ready", req_ready, 4'b0001);
    sb_q.push_back({8'd0, 8'hA5});
    step();
    req_valid = '0;
    #1;
    chk("t1_ready_after", req_ready, 0);
    chk("t1_arb_busy", arb_busy, 1);
    wait_idle(100, "t1_idle");
    chk("t1_busy_fell", tx_busy, 0);
    chk("t1_hold_data", tx_data, 8'hA5);
    chk("t1_hold_gid", grant_id, 0);

    // All four requesting: fresh round-robin order from requester 0
    do_reset();
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    sb_q.push_back({8'd0, 8'h10});
    sb_q.push_back({8'd1, 8'h11});
    sb_q.push_back({8'd2, 8'h12});
    sb_q.push_back({8'd3, 8'h13});
    sb_q.push_back({8'd0, 8'h10});
    base = send_cnt;
    wait_sends(base + 5, 600, "t2_sends");
    req_valid = '0;
    wait_idle(100, "t2_idle");

    // Wrap-around: after granting 2, requesters 0 and 2 -> 0 then 2
    do_reset();
    req_data = {8'h33, 8'h22, 8'h11, 8'h20};
    req_valid = 4'b0100;
    sb_q.push_back({8'd2, 8'h22});
    base = send_cnt;
    wait_sends(base + 1, 50, "t3_first");
    req_valid = 4'b0101;
    sb_q.push_back({8'd0, 8'h20});
    sb_q.push_back({8'd2, 8'h22});
    wait_sends(base + 3, 200, "t3_sends");
    req_valid = '0;
    wait_idle(100, "t3_idle");

    // Transmitter never acknowledges: timeout pulse, then a normal grant
    do_reset();
    mdl_en = 1'b0;
    req_data[15:8] = 8'h5A;
    req_valid = 4'b0010;
    sb_q.push_back({8'd1, 8'h5A});
    step();
    req_valid = '0;
    base = to_cnt;
    for (int i = 0; i < 40 && to_cnt == base; i++) step();
    chk("t4_timeout_seen", to_cnt, base + 1);
    mdl_en = 1'b1;
    req_data[7:0] = 8'h77;
    req_valid = 4'b0001;
    #1;
    chk("t4_regrant_ready", req_ready, 4'b0001);
    sb_q.push_back({8'd0, 8'h77});
    step();
    req_valid = '0;
    wait_idle(100, "t4_idle");
    chk("t4_no_extra_timeout", to_cnt, base + 1);

    // External busy blocks the grant until it falls
    ext_busy = 1'b1;
    req_data[15:8] = 8'h33;
    req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_blocked", req_ready, 0);
      step();
    end
    ext_busy = 1'b0;
    #1;
    chk("t5_ready", req_ready, 4'b0010);
    sb_q.push_back({8'd1, 8'h33});
    step();
    req_valid = '0;
    wait_idle(100, "t5_idle");

    // Reset during WAIT_DONE while the transmitter keeps its frame going
    req_data[7:0] = 8'h44;
    req_valid = 4'b0001;
    sb_q.push_back({8'd0, 8'h44});
    step();
    req_valid = '0;
    for (int i = 0; i < 20 && !tx_busy; i++) step();
    step();
    step();
    chk("t6_in_frame", arb_busy, 1);
    reset = 1'b1;
    req_data[15:8] = 8'h66;
    req_valid = 4'b0010;
    #1;
    chk("t6_rst_arb_busy", arb_busy, 0);
    chk("t6_rst_tx_send", tx_send, 0);
    chk("t6_rst_tx_data", tx_data, 0);
    chk("t6_rst_grant_id", grant_id, 0);
    chk("t6_rst_ready", req_ready, 0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("t6_busy_still", tx_busy, 1);
    chk("t6_no_grant", req_ready, 0);
    for (int i = 0; i < 40 && tx_busy; i++) step();
    chk("t6_busy_fell", tx_busy, 0);
    #1;
    chk("t6_ready", req_ready, 4'b0010);
    sb_q.push_back({8'd1, 8'h66});
    step();
    req_valid = '0;
    wait_idle(100, "t6_idle");

    chk("sb_empty", sb_q.size(), 0);
    chk("timeouts_total", to_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
